// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock.
// Optional overflow output ov with SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ov
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic             ai;
  logic             bi;
  logic             diff;
  logic             br_next;
  logic             last;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             a_msb_q;
  logic             b_msb_q;
`endif

  assign ai      = sa_q[0];
  assign bi      = sb_q[0];
  assign diff    = ai ^ bi ^ br_q;
  assign br_next = (~ai & bi) | (~(ai ^ bi) & br_q);
  assign last    = (cnt_q == CW'(WIDTH - 1));

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      d       <= '0;
      bo      <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ov      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sa_q  <= a;
            sb_q  <= b;
            br_q  <= bin;
            cnt_q <= '0;
            res_q <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          br_q  <= br_next;
          res_q <= {diff, res_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CW'(1);
          // last diff bit is the result MSB
          if (last) begin
            d  <= {diff, res_q[WIDTH-1:1]};
            bo <= br_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ov <= (a_msb_q != b_msb_q) && (diff != a_msb_q);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor, WIDTH=8.
// Directed cases plus random operands against an arithmetic model.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] d;
  logic       bo;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic       ov;
`endif

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .bin(bin),
    .busy(busy),
    .done(done),
    .d(d),
    .bo(bo)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ov(ov)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib,
                                 input logic ibin);
    exp_t e;
    int   r;
    logic [31:0] rv;
    r    = int'(ia) - int'(ib) - int'(ibin);
    rv   = r;
    e.d  = rv[7:0];
    e.bo = (r < 0);
    e.ov = (ia[7] != ib[7]) && (e.d[7] != ia[7]);
    return e;
  endfunction

  // Monitor: pop and compare whenever the DUT signals done.
  always @(negedge clk) begin
    if (done) begin
      n_checks++;
      if (prev_done) begin
        n_fail++;
        $display("FAIL done_consecutive: got 1, expected 0");
      end
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: d=%0h bo=%0b", d, bo);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_d", int'(d), int'(e.d));
        chk("result_bo", int'(bo), int'(e.bo));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("result_ov", int'(ov), int'(e.ov));
`endif
      end
    end
    prev_done = done;
  end

  task automatic op(input logic [7:0] ia, input logic [7:0] ib,
                    input logic ibin, input bit disturb);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    a     = ia;
    b     = ib;
    bin   = ibin;
    @(posedge clk);
    #1;
    exp_q.push_back(model(ia, ib, ibin));
    chk("busy_after_accept", int'(busy), 1);
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    bin   = 1'($urandom);
    n     = 1;
    while (!done && n < 40) begin
      if (disturb) begin
        start = 1'($urandom_range(0, 1));
        a     = 8'($urandom);
        b     = 8'($urandom);
        bin   = 1'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk("latency", n, 9);
    chk("busy_at_done", int'(busy), 1);
    @(posedge clk);
    #1;
    chk("idle_after_done", int'({busy, done}), 0);
  endtask

  initial begin
    int n;
    int last_cyc;
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h5A;
    b     = 8'h11;
    bin   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_d", int'(d), 0);
    chk("reset_bo", int'(bo), 0);
    rst   = 1'b0;
    start = 1'b0;

    op(8'h05, 8'h03, 1'b0, 1'b0);
    op(8'h03, 8'h05, 1'b0, 1'b0);
    op(8'h00, 8'h00, 1'b1, 1'b0);
    op(8'h80, 8'h01, 1'b0, 1'b0);
    op(8'h7F, 8'h01, 1'b0, 1'b0);
    op(8'hAA, 8'h55, 1'b0, 1'b1);

    // Abort with reset on the 4th SHIFT edge.
    @(negedge clk);
    start = 1'b1;
    a     = 8'h33;
    b     = 8'h11;
    bin   = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_d", int'(d), 0);
    chk("abort_bo", int'(bo), 0);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_stays_idle", int'(busy), 0);
    op(8'h10, 8'h01, 1'b0, 1'b0);

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h01;
    bin   = 1'b0;
    for (int k = 0; k < 3; k++) exp_q.push_back(model(8'hFF, 8'h01, 1'b0));
    last_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!done && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (k == 0) chk("b2b_first_latency", n, 9);
      else chk("b2b_period", cyc - last_cyc, 10);
      last_cyc = cyc;
      if (k == 2) start = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("b2b_idle", int'(busy), 0);

    for (int i = 0; i < 24; i++)
      op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), (i % 4) == 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; sampled on the edge that accepts start.
REQ-006 b  input  WIDTH  subtrahend; sampled on the edge that accepts start.
REQ-007 bin  input  1  borrow-in; sampled on the edge that accepts start.
REQ-008 busy  output  1  high while an operation is in progress (SHIFT or DONE).
REQ-009 done  output  1  one-cycle pulse; d and bo are valid while it is high.
REQ-010 d  output  WIDTH  difference a - b - bin, modulo 2^WIDTH.
REQ-011 bo  output  1  borrow-out; 1 when a < b + bin, unsigned.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE, all registered.
REQ-013 In IDLE, a rising edge with start=1 SHALL load a, b and bin into internal shift and borrow registers, clear the bit counter and enter SHIFT.
REQ-014 In SHIFT, each edge SHALL process one bit, LSB first: diff = ai ^ bi ^ br; br_next = (~ai & bi) | (~(ai ^ bi) & br); diff shifts into the result register MSB end.
REQ-015 After exactly WIDTH SHIFT edges, the FSM SHALL enter DONE. On that same edge d SHALL take the full result and bo the final borrow.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 Latency from the accepting edge to done=1 SHALL be WIDTH+1 edges (9 for WIDTH=8).
REQ-018 d and bo SHALL hold their values from DONE until the next DONE or reset.
REQ-019 start SHALL be ignored in SHIFT and DONE: no restart and no corruption of the operation in progress.
REQ-020 start held high continuously SHALL begin a new operation on the first edge back in IDLE, giving back-to-back throughput of one result per WIDTH+2 cycles.
REQ-021 Changes on a, b and bin after the accepting edge SHALL NOT affect the result.
REQ-022 busy SHALL be 1 exactly when the state is SHIFT or DONE.

Reset
REQ-023 rst=1 at a rising edge SHALL force IDLE and clear the counter and borrow register; it SHALL set busy=0, done=0, d=0 and bo=0 (and ov=0 when present).
REQ-024 rst SHALL take priority over start.
REQ-025 Reset during SHIFT or DONE SHALL abort the operation with no done pulse.

Configuration
REQ-026 Macro SERIAL_SUBTRACTOR_OVF_EN: when defined, the block SHALL have an extra output port ov (1 bit). ov is the two's-complement overflow, (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]). It SHALL update and hold exactly like d.
REQ-027 When SERIAL_SUBTRACTOR_OVF_EN is undefined, port ov and its logic SHALL be absent; all other behaviour is identical.

Verification (WIDTH=8)
REQ-028 a=0x05, b=0x03, bin=0, start pulse -> done on the 9th edge after acceptance, d=0x02, bo=0, busy high for 9 cycles.
REQ-029 a=0x03, b=0x05, bin=0 -> d=0xFE, bo=1; a=0x00, b=0x00, bin=1 -> d=0xFF, bo=1.
REQ-030 With OVF_EN defined: a=0x80, b=0x01 -> d=0x7F, bo=0, ov=1; a=0x7F, b=0x01 -> d=0x7E, ov=0.
REQ-031 Start a=0xAA, b=0x55, then pulse start with other operands during SHIFT -> single done, d=0x55, bo=0.
REQ-032 rst asserted on the 4th SHIFT edge -> busy=0, d=0x00, bo=0 next cycle, no done; then a new start (a=0x10, b=0x01) -> d=0x0F 9 edges later.
REQ-033 start held high with a=0xFF, b=0x01 -> results d=0xFE every 10 cycles, done never high on consecutive cycles.
